apb_prci_rstseq: RTL and testbench

// - APB slave on the PRCI slot of bus1 (mapinfo/apbi/apbo port of the SoC top); sequences the reset releases of the SoC.
// - Gates release on PLL lock, then releases debug reset, then DDR reset, then system reset, in that order.
// - Re-asserts system reset on debug-module reset, software request or PLL lock loss.
// - Records the reset cause in a W1C status register.

---
 rtl/apb_prci_rstseq.sv | 255 +++++++++++++++++++++++++
 tb/tb_apb_prci_rstseq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_prci_rstseq.sv
// PRCI reset sequencer: PLL-lock gated dbg -> ddr -> sys release, APB regs.
// Define PRCI_WDOG_EN to add the 32-bit software watchdog at offset 0x0C.

package apb_prci_pkg;

   typedef struct packed {
      logic [31:0] baseaddr;
      logic [31:0] addrmask;
   } mapinfo_type;

   typedef struct packed {
      logic [15:0] vid;
      logic [15:0] did;
      logic [31:0] addr_start;
      logic [31:0] addr_end;
   } dev_config_type;

   typedef struct packed {
      logic        psel;
      logic        penable;
      logic        pwrite;
      logic [31:0] paddr;
      logic [31:0] pwdata;
   } apb_in_type;

   typedef struct packed {
      logic [31:0] prdata;
      logic        pready;
      logic        pslverr;
   } apb_out_type;

endpackage

module apb_prci_rstseq
   import apb_prci_pkg::*;
#(
   parameter int LOCK_STABLE = 32,
   parameter int HOLD_CYCLES = 16
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_pll_lock,
   input  logic           i_dmreset,
   input  mapinfo_type    i_mapinfo,
   output dev_config_type o_cfg,
   input  apb_in_type     i_apbi,
   output apb_out_type    o_apbo,
   output logic           o_sys_nrst,
   output logic           o_dbg_nrst,
   output logic           o_ddr_nrst
);

   localparam int LW = $clog2(LOCK_STABLE + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE - 1);
   localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_STABLE);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_REL_DBG   = 3'd1,
      ST_REL_DDR   = 3'd2,
      ST_RUN       = 3'd3,
      ST_SYS_RST   = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          sys_nrst_q, sys_nrst_d;
   logic          dbg_nrst_q, dbg_nrst_d;
   logic          ddr_nrst_q, ddr_nrst_d;
   logic [3:0]    cause_q, cause_d, cause_set, cause_w1c;
   logic          swreq_q, swreq_d;
   logic          pready_q, pready_d;
   logic [31:0]   prdata_q, prdata_d, rdata;
   logic          acc, wr_en, rd_en, wd_fire;
   logic [9:0]    off;
   logic          unused_apb_bits;
`ifdef PRCI_WDOG_EN
   logic [31:0]   wdog_q, wdog_d;
`endif

   assign unused_apb_bits = ^{i_apbi.paddr, i_apbi.pwdata};

   // PnP descriptor for the bus1 slot taken straight from the map entry
   always_comb begin
      o_cfg            = '0;
      o_cfg.vid        = 16'h00F1;
      o_cfg.did        = 16'h0077;
      o_cfg.addr_start = i_mapinfo.baseaddr;
      o_cfg.addr_end   = i_mapinfo.baseaddr | ~i_mapinfo.addrmask;
   end

   // APB decode: one-cycle pready after the access phase, read mux
   always_comb begin
      acc       = i_apbi.psel & i_apbi.penable & ~pready_q;
      wr_en     = acc & i_apbi.pwrite;
      rd_en     = acc & ~i_apbi.pwrite;
      off       = i_apbi.paddr[11:2];
      cause_w1c = '0;
      if (wr_en && off == 10'h001) cause_w1c = i_apbi.pwdata[3:0];
      swreq_d   = wr_en && off == 10'h002 && i_apbi.pwdata[0];
      rdata     = '0;
      case (off)
         10'h000: rdata = {25'd0, state_q, ddr_nrst_q, dbg_nrst_q,
                           sys_nrst_q, i_pll_lock};
         10'h001: rdata = {28'd0, cause_q};
`ifdef PRCI_WDOG_EN
         10'h003: rdata = wdog_q;
`endif
         default: rdata = '0;
      endcase
      pready_d = acc;
      prdata_d = rd_en ? rdata : '0;
   end

`ifdef PRCI_WDOG_EN
   assign wd_fire = (state_q == ST_RUN) && (wdog_q == 32'd1);

   // Watchdog: counts down only in RUN, cleared whenever a reset is entered
   always_comb begin
      wdog_d = wdog_q;
      if (state_q == ST_RUN && wdog_q != 32'd0) wdog_d = wdog_q - 32'd1;
      if (wr_en && off == 10'h003) wdog_d = i_apbi.pwdata;
      if (state_d != state_q &&
          (state_d == ST_SYS_RST || state_d == ST_WAIT_LOCK))
         wdog_d = '0;
   end

   // Watchdog counter register
   always_ff @(posedge i_clk) begin
      if (i_rst) wdog_q <= '0;
      else       wdog_q <= wdog_d;
   end
`else
   assign wd_fire = 1'b0;
`endif

   // Sequencer next state, counters, cause events and reset outputs
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      hold_d     = hold_q;
      cause_set  = '0;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (!i_pll_lock) begin
               lock_cnt_d = '0;
            end else if (lock_cnt_q == LOCK_LAST) begin
               state_d    = ST_REL_DBG;
               lock_cnt_d = '0;
               hold_d     = '0;
            end else if (lock_cnt_q != LOCK_MAX) begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
         ST_REL_DBG: begin
            if (hold_q == HOLD_LAST) begin
               state_d = ST_REL_DDR;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_REL_DDR: begin
            if (!i_pll_lock) begin
               state_d      = ST_WAIT_LOCK;
               hold_d       = '0;
               cause_set[1] = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
               state_d = ST_RUN;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_RUN: begin
            cause_set[2] = i_dmreset | swreq_q;
            cause_set[3] = wd_fire;
            if (!i_pll_lock) begin
               state_d      = ST_WAIT_LOCK;
               cause_set[1] = 1'b1;
            end else if (i_dmreset | swreq_q | wd_fire) begin
               state_d = ST_SYS_RST;
               hold_d  = '0;
            end
         end
         ST_SYS_RST: begin
            if (!i_pll_lock) begin
               state_d      = ST_WAIT_LOCK;
               hold_d       = '0;
               cause_set[1] = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
               if (!i_dmreset) begin
                  state_d = ST_RUN;
                  hold_d  = '0;
               end
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d    = ST_WAIT_LOCK;
            lock_cnt_d = '0;
            hold_d     = '0;
         end
      endcase
      sys_nrst_d = (state_d == ST_RUN) &&
                   (state_q == ST_RUN || state_q == ST_SYS_RST);
      dbg_nrst_d = dbg_nrst_q | (state_d == ST_REL_DBG);
      ddr_nrst_d = (state_d != ST_WAIT_LOCK) &&
                   (ddr_nrst_q | (state_d == ST_REL_DDR));
      cause_d    = (cause_q & ~cause_w1c) | cause_set;
   end

   // State and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_WAIT_LOCK;
         lock_cnt_q <= '0;
         hold_q     <= '0;
         sys_nrst_q <= 1'b0;
         dbg_nrst_q <= 1'b0;
         ddr_nrst_q <= 1'b0;
         cause_q    <= 4'b0001;
         swreq_q    <= 1'b0;
         pready_q   <= 1'b0;
         prdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         hold_q     <= hold_d;
         sys_nrst_q <= sys_nrst_d;
         dbg_nrst_q <= dbg_nrst_d;
         ddr_nrst_q <= ddr_nrst_d;
         cause_q    <= cause_d;
         swreq_q    <= swreq_d;
         pready_q   <= pready_d;
         prdata_q   <= prdata_d;
      end
   end

   // Response bundle and reset outputs
   always_comb begin
      o_apbo         = '0;
      o_apbo.prdata  = prdata_q;
      o_apbo.pready  = pready_q;
      o_apbo.pslverr = 1'b0;
      o_sys_nrst     = sys_nrst_q;
      o_dbg_nrst     = dbg_nrst_q;
      o_ddr_nrst     = ddr_nrst_q;
   end

endmodule

// File: tb/tb_apb_prci_rstseq.sv
// Bench for apb_prci_rstseq with LOCK_STABLE=4, HOLD_CYCLES=3.
// Honours PRCI_WDOG_EN for the watchdog expectations.

module tb_apb_prci_rstseq;
   import apb_prci_pkg::*;

   localparam int LS = 4;
   localparam int HC = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           lock = 1'b0;
   logic           dmr = 1'b0;
   mapinfo_type    mi;
   dev_config_type cfg;
   apb_in_type     apbi = '0;
   apb_out_type    apbo;
   logic           sys, dbg, ddr;

   int nchk = 0;
   int nerr = 0;
   bit lockpat[64];

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] mask;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[11];

   always #5 clk = ~clk;

   apb_prci_rstseq #(.LOCK_STABLE(LS), .HOLD_CYCLES(HC)) dut (
      .i_clk(clk), .i_rst(rst), .i_pll_lock(lock), .i_dmreset(dmr),
      .i_mapinfo(mi), .o_cfg(cfg), .i_apbi(apbi), .o_apbo(apbo),
      .o_sys_nrst(sys), .o_dbg_nrst(dbg), .o_ddr_nrst(ddr)
   );

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      nchk++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      lock = 1'b0;
      dmr = 1'b0;
      apbi = '0;
      repeat (3) tick();
   endtask

   task automatic apb(input logic wr, input logic [11:0] a,
                      input logic [31:0] wd, output logic [31:0] d,
                      output int lat, output logic sys_rdy);
      apbi.psel = 1'b1;
      apbi.penable = 1'b0;
      apbi.pwrite = wr;
      apbi.paddr = {20'h0, a};
      apbi.pwdata = wd;
      tick();
      apbi.penable = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!apbo.pready && lat < 8);
      chk("apb_pready", {31'd0, apbo.pready}, 32'd1);
      chk("apb_pslverr", {31'd0, apbo.pslverr}, 32'd0);
      d = apbo.prdata;
      sys_rdy = sys;
      tick();
      apbi = '0;
   endtask

   task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
      int l;
      logic s;
      apb(1'b0, a, 32'd0, d, l, s);
   endtask

   task automatic apb_wr(input logic [11:0] a, input logic [31:0] wd);
      int l;
      logic s;
      logic [31:0] d;
      apb(1'b1, a, wd, d, l, s);
   endtask

   task automatic wait_sys();
      for (int k = 0; k < 40 && !sys; k++) tick();
      chk("wait_sys", {31'd0, sys}, 32'd1);
   endtask

   // Release time is the first edge closing LS contiguous lock highs.
   task automatic run_bringup(input string nm);
      int t0, run;
      logic [2:0] e;
      t0 = 0;
      run = 0;
      for (int n = 1; n < 64; n++) begin
         if (t0 == 0) begin
            run = lockpat[n] ? run + 1 : 0;
            if (run == LS) t0 = n;
         end else begin
            lockpat[n] = 1'b1;
         end
      end
      rst = 1'b0;
      for (int n = 1; n <= t0 + 2 * HC + 4; n++) begin
         lock = lockpat[n];
         tick();
         e = {n >= t0 + 2 * HC + 1, n >= t0 + HC, n >= t0};
         chk(nm, {29'd0, sys, ddr, dbg}, {29'd0, e});
      end
   endtask

   task automatic dm_pulse(input int w);
      int c;
      c = 0;
      dmr = 1'b1;
      for (int k = 0; k < w; k++) begin
         tick();
         if (!sys) c++;
      end
      dmr = 1'b0;
      while (!sys && c < 40) begin
         tick();
         if (!sys) c++;
      end
      chk($sformatf("dm_low_w%0d", w), c, (w > HC) ? w : HC);
      chk("dm_dbg_ddr", {30'd0, dbg, ddr}, 32'd3);
      tick();
   endtask

   initial begin
      logic [31:0] d;
      int          lat, n;
      logic        s;

      tbl[0]  = '{1'b0, 12'h000, 32'h0, 32'hF, 32'hF};
      tbl[1]  = '{1'b0, 12'h004, 32'h0, 32'hF, 32'h1};
      tbl[2]  = '{1'b1, 12'h004, 32'h1, 32'h0, 32'h0};
      tbl[3]  = '{1'b0, 12'h004, 32'h0, 32'hFFFFFFFF, 32'h0};
      tbl[4]  = '{1'b0, 12'h008, 32'h0, 32'hFFFFFFFF, 32'h0};
      tbl[5]  = '{1'b1, 12'h008, 32'h2, 32'h0, 32'h0};
      tbl[6]  = '{1'b0, 12'h00C, 32'h0, 32'hFFFFFFFF, 32'h0};
      tbl[7]  = '{1'b1, 12'h010, 32'hFFFFFFFF, 32'h0, 32'h0};
      tbl[8]  = '{1'b0, 12'h010, 32'h0, 32'hFFFFFFFF, 32'h0};
      tbl[9]  = '{1'b0, 12'h3FC, 32'h0, 32'hFFFFFFFF, 32'h0};
      tbl[10] = '{1'b1, 12'h004, 32'hF, 32'h0, 32'h0};

      mi.baseaddr = 32'h8000_1000;
      mi.addrmask = 32'hFFFF_F000;

      do_reset();
      chk("rst_nrst", {29'd0, sys, ddr, dbg}, 32'd0);
      chk("rst_pready", {31'd0, apbo.pready}, 32'd0);
      chk("rst_prdata", apbo.prdata, 32'd0);
      chk("rst_pslverr", {31'd0, apbo.pslverr}, 32'd0);
      chk("cfg_start", cfg.addr_start, 32'h8000_1000);
      chk("cfg_end", cfg.addr_end, 32'h8000_1FFF);

      for (int i = 0; i < 64; i++) lockpat[i] = 1'b1;
      run_bringup("bringup_fixed");
      apb_rd(12'h004, d);
      chk("cause_por", d, 32'h1);
      apb_rd(12'h000, d);
      chk("status_run", d & 32'hF, 32'hF);

      apb(1'b1, 12'h008, 32'h1, d, lat, s);
      chk("swrst_lat", lat, 1);
      chk("swrst_sys_at_rdy", {31'd0, s}, 32'd1);
      chk("swrst_sys_after", {29'd0, sys, ddr, dbg}, 32'b011);
      n = 0;
      for (int k = 0; k < 40 && !sys; k++) begin
         n++;
         tick();
      end
      chk("swrst_low", n, HC);
      apb_rd(12'h004, d);
      chk("cause_sw", d, 32'h5);
      apb_wr(12'h004, 32'h4);
      apb_rd(12'h004, d);
      chk("cause_w1c", d, 32'h1);

      dm_pulse(1);
      dm_pulse(5);
      for (int i = 0; i < 6; i++) dm_pulse($urandom_range(1, 6));
      apb_rd(12'h004, d);
      chk("cause_dm", d, 32'h5);

      apbi.psel = 1'b1;
      apbi.penable = 1'b0;
      apbi.pwrite = 1'b1;
      apbi.paddr = 32'h004;
      apbi.pwdata = 32'h4;
      tick();
      apbi.penable = 1'b1;
      dmr = 1'b1;
      tick();
      dmr = 1'b0;
      chk("race_pready", {31'd0, apbo.pready}, 32'd1);
      tick();
      apbi = '0;
      wait_sys();
      apb_rd(12'h004, d);
      chk("cause_race", d, 32'h5);
      apb_wr(12'h004, 32'h4);

      for (int i = 0; i < 11; i++) begin
         apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, d, lat, s);
         chk($sformatf("tbl%0d_lat", i), lat, 1);
         if (!tbl[i].wr)
            chk($sformatf("tbl%0d_rd", i), d & tbl[i].mask, tbl[i].exp);
         chk($sformatf("tbl%0d_sys", i), {31'd0, sys}, 32'd1);
      end

      apb_wr(12'h00C, 32'd5);
`ifdef PRCI_WDOG_EN
      n = 0;
      while (sys && n < 20) begin
         tick();
         n++;
      end
      chk("wdog_fall", n + 1, 5);
      wait_sys();
      apb_rd(12'h004, d);
      chk("wdog_cause", d, 32'h8);
      apb_rd(12'h00C, d);
      chk("wdog_cleared", d, 32'h0);
`else
      n = 0;
      repeat (12) begin
         tick();
         if (!sys) n++;
      end
      chk("wdog_off_low", n, 0);
      apb_rd(12'h00C, d);
      chk("wdog_off_rd", d, 32'h0);
      apb_rd(12'h004, d);
      chk("wdog_off_cause", d, 32'h0);
`endif
      apb_wr(12'h004, 32'hF);

      lock = 1'b0;
      tick();
      chk("lockloss_out", {29'd0, sys, ddr, dbg}, 32'b001);
      lock = 1'b1;
      n = 0;
      while (!sys && n < 30) begin
         tick();
         n++;
      end
      chk("lockloss_relock", n, LS + 2 * HC + 1);
      apb_rd(12'h004, d);
      chk("cause_lockloss", d, 32'h2);
      apb_wr(12'h004, 32'hF);

      lock = 1'b0;
      dmr = 1'b1;
      tick();
      dmr = 1'b0;
      chk("both_out", {29'd0, sys, ddr, dbg}, 32'b001);
      apb_rd(12'h000, d);
      chk("both_status", d & 32'hF, 32'h4);
      lock = 1'b1;
      wait_sys();
      chk("both_dbg", {31'd0, dbg}, 32'd1);
      apb_rd(12'h004, d);
      chk("cause_both", d, 32'h6);

      rst = 1'b1;
      tick();
      chk("midrst_nrst", {29'd0, sys, ddr, dbg}, 32'd0);
      chk("midrst_pready", {31'd0, apbo.pready}, 32'd0);
      rst = 1'b0;
      n = 0;
      while (!sys && n < 30) begin
         tick();
         n++;
      end
      chk("midrst_relock", n, LS + 2 * HC + 1);
      apb_rd(12'h004, d);
      chk("midrst_cause", d, 32'h1);

      do_reset();
      for (int i = 0; i < 64; i++) lockpat[i] = 1'b1;
      lockpat[3] = 1'b0;
      run_bringup("bringup_toggle");

      for (int t = 0; t < 10; t++) begin
         do_reset();
         for (int i = 0; i < 64; i++)
            lockpat[i] = (i > 24) ? 1'b1 : ($urandom_range(0, 3) != 0);
         run_bringup($sformatf("bringup_rand%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
